// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, iteration count.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage : mdu_pkg

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO; one shift register and one
// WIDTH+1-bit adder are shared by shift-add multiply and restoring divide.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  mdu_op_e          op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_c, a_neg_c, b_neg_c, is_div_c, div_ok_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quo_c, rem_c;
  logic [WIDTH:0]   add_x_c, add_y_c, add_res_c;
  logic             add_cin_c;
  logic [ACC_W-1:0] step_c, prod_c;

  // Operand magnitudes and sign flags captured on acceptance
  always_comb begin
    signed_c = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg_c  = signed_c & op_a[WIDTH-1];
    b_neg_c  = signed_c & op_b[WIDTH-1];
    a_mag_c  = a_neg_c ? (~op_a + WIDTH'(1)) : op_a;
    b_mag_c  = b_neg_c ? (~op_b + WIDTH'(1)) : op_b;
  end

  // Shared adder: upper+b for multiply, shifted remainder minus b for divide
  always_comb begin
    is_div_c = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    if (is_div_c) begin
      add_x_c   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
      add_y_c   = ~{1'b0, opb_q};
      add_cin_c = 1'b1;
    end else begin
      add_x_c   = {1'b0, acc_q[ACC_W-1:WIDTH]};
      add_y_c   = acc_q[0] ? {1'b0, opb_q} : '0;
      add_cin_c = 1'b0;
    end
    add_res_c = add_x_c + add_y_c + {{WIDTH{1'b0}}, add_cin_c};
    div_ok_c  = ~add_res_c[WIDTH];
    if (is_div_c) begin
      step_c = {div_ok_c ? add_res_c[WIDTH-1:0] : acc_q[ACC_W-2:WIDTH-1],
                acc_q[WIDTH-2:0], div_ok_c};
    end else begin
      step_c = {add_res_c, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_c = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quo_c  = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_c  = rneg_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              acc_d   = {{WIDTH{1'b0}}, a_mag_c};
              opb_d   = b_mag_c;
              op_d    = mdu_op_e'(op);
              neg_d   = a_neg_c ^ b_neg_c;
              rneg_d  = a_neg_c;
              bzero_d = (op_b == '0);
              cnt_d   = '0;
              state_d = RUN;
            end
            MDU_MTHI: hi_d = op_a;
            MDU_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_c) begin
          // Divide by zero leaves remainder = dividend; quotient is forced to all ones
          lo_d = bzero_q ? '1 : quo_c;
          hi_d = rem_c;
        end else begin
          lo_d = prod_c[WIDTH-1:0];
          hi_d = prod_c[ACC_W-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= MDU_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: result table plus handshake and reset sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request at a negedge; returns #1 after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 32'h5A5A_A5A5;
    op_b  = 32'hA5A5_5A5A;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!done && lat < 200);
  endtask

  int lat, lat2, seen;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
    vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{3'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};

    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // MTHI then MTLO on consecutive edges, then a no-op code
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    op_a  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_busy", 32'(busy), 32'd0);
    @(negedge clk);
    op   = 3'd5;
    op_a = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    chk("mtlo_done", 32'(done), 32'd0);
    @(negedge clk);
    op   = 3'd6;
    op_a = 32'h1111_1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_done", 32'(done), 32'd0);
    chk("nop_hi", hi, 32'hDEAD_BEEF);
    chk("nop_lo", lo, 32'h0BAD_F00D);

    // start asserted every busy cycle with changing operands, including MTHI/MTLO
    issue(3'd3, 32'd100, 32'd7);
    lat = 0;
    do begin
      start = 1'b1;
      op    = 3'(lat % 8);
      op_a  = $urandom;
      op_b  = $urandom;
      @(posedge clk);
      lat++;
      #1;
    end while (!done && lat < 200);
    start = 1'b0;
    chk("busy_start_latency", 32'(lat), 32'd33);
    chk("busy_start_hi", hi, 32'd2);
    chk("busy_start_lo", lo, 32'd14);

    // Back-to-back: new request in the done cycle
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(lat);
    chk("b2b_first_latency", 32'(lat), 32'd33);
    chk("b2b_first_hi", hi, 32'h0000_0002);
    start = 1'b1;
    op    = 3'd3;
    op_a  = 32'd100;
    op_b  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done(lat2);
    chk("b2b_done_spacing", 32'(lat2 + 1), 32'd34);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_second_lo", lo, 32'd14);

    // Reset in the middle of a DIVU aborts it
    issue(3'd3, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd3;
    op_a  = 32'd5;
    op_b  = 32'd1;
    @(posedge clk);
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_hi", hi, 32'd0);
    chk("midrun_reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("midrun_reset_no_done", 32'(seen), 32'd0);
    chk("midrun_reset_hi_after", hi, 32'd0);
    chk("midrun_reset_lo_after", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mult_div_unit
